// File: rtl/out_alu_control_unit_pkg.sv
// Shared ALU output-path definitions: widths, operation tags and source selectors.
package out_alu_control_unit_pkg;

  localparam int DATA_SIZE      = 16;
  localparam int ID_SIZE        = 8;
  localparam int OPERATION_SIZE = 2;
  localparam int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ADD  = 2'b01,
    OP_MUL  = 2'b10
  } op_e;

  typedef enum logic {
    SRC_ADD = 1'b0,
    SRC_MUL = 1'b1
  } src_e;

  function automatic op_e src_to_op(input src_e src);
    return (src == SRC_ADD) ? OP_ADD : OP_MUL;
  endfunction

endpackage

// File: rtl/out_alu_control_unit_if.sv
// Result-in / FIFO_OUT-write bundle between the ALU units and the output control unit.
interface out_alu_control_unit_if #(
  parameter int DATA_SIZE      = out_alu_control_unit_pkg::DATA_SIZE,
  parameter int ID_SIZE        = out_alu_control_unit_pkg::ID_SIZE,
  parameter int OPERATION_SIZE = out_alu_control_unit_pkg::OPERATION_SIZE,
  parameter int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE
);

  logic                      a_valid_res;
  logic [DATA_SIZE-1:0]      a_result;
  logic [ID_SIZE-1:0]        a_id;
  logic                      a_res_ready;
  logic                      m_valid_res;
  logic [DATA_SIZE-1:0]      m_result;
  logic [ID_SIZE-1:0]        m_id;
  logic                      m_res_ready;
  logic                      full_out;
  logic                      w_en_out;
  logic [FIFO_OUT_WIDTH-1:0] fifo_out_data;
  logic [15:0]               wr_count;

  modport slave (
    input  a_valid_res, a_result, a_id,
    input  m_valid_res, m_result, m_id,
    input  full_out,
    output a_res_ready, m_res_ready, w_en_out, fifo_out_data, wr_count
  );

  modport master (
    output a_valid_res, a_result, a_id,
    output m_valid_res, m_result, m_id,
    output full_out,
    input  a_res_ready, m_res_ready, w_en_out, fifo_out_data, wr_count
  );

endinterface

// File: rtl/d_ff_async_en.sv
// Generic register with enable and asynchronous active-high clear to zero.
module d_ff_async_en #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/result_slot.sv
// One-entry holding register for a unit result: {result, id} plus an occupancy flag.
module result_slot #(
  parameter int DATA_SIZE = 16,
  parameter int ID_SIZE   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [DATA_SIZE-1:0] result_in,
  input  logic [ID_SIZE-1:0]   id_in,
  output logic [DATA_SIZE-1:0] result,
  output logic [ID_SIZE-1:0]   id,
  output logic                 full
);

  logic [DATA_SIZE+ID_SIZE-1:0] entry;

  d_ff_async_en #(.WIDTH(DATA_SIZE + ID_SIZE)) u_data (
    .clk (clk),
    .rst (rst),
    .en  (load),
    .d   ({result_in, id_in}),
    .q   (entry)
  );

  // load and clear never coincide: load requires the slot empty, clear requires it full
  d_ff_async_en #(.WIDTH(1)) u_full (
    .clk (clk),
    .rst (rst),
    .en  (load | clear),
    .d   (load),
    .q   (full)
  );

  assign result = entry[DATA_SIZE+ID_SIZE-1:ID_SIZE];
  assign id     = entry[ID_SIZE-1:0];

endmodule

// File: rtl/out_alu_control_unit.sv
// Merges adder and multiplier results into FIFO_OUT, one write per cycle, round-robin on contention.
module out_alu_control_unit #(
  parameter int DATA_SIZE      = out_alu_control_unit_pkg::DATA_SIZE,
  parameter int ID_SIZE        = out_alu_control_unit_pkg::ID_SIZE,
  parameter int OPERATION_SIZE = out_alu_control_unit_pkg::OPERATION_SIZE,
  parameter int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE
) (
  input logic                   clk,
  input logic                   rst,
  out_alu_control_unit_if.slave bus
);

  import out_alu_control_unit_pkg::*;

  logic                 a_full, m_full;
  logic                 a_load, m_load;
  logic                 a_clear, m_clear;
  logic [DATA_SIZE-1:0] a_slot_result, m_slot_result;
  logic [ID_SIZE-1:0]   a_slot_id, m_slot_id;
  logic                 prio_bit;
  src_e                 sel;
  logic                 any_full;
  logic                 wr_fire;
  logic [15:0]          count;
  logic [FIFO_OUT_WIDTH-1:0] entry;

  // Ready comes only from the registered occupancy flags, never from full_out
  assign a_load = bus.a_valid_res & ~a_full;
  assign m_load = bus.m_valid_res & ~m_full;

  result_slot #(.DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE)) u_add_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (a_load),
    .clear     (a_clear),
    .result_in (bus.a_result),
    .id_in     (bus.a_id),
    .result    (a_slot_result),
    .id        (a_slot_id),
    .full      (a_full)
  );

  result_slot #(.DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE)) u_mul_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (m_load),
    .clear     (m_clear),
    .result_in (bus.m_result),
    .id_in     (bus.m_id),
    .result    (m_slot_result),
    .id        (m_slot_id),
    .full      (m_full)
  );

  always_comb begin
    sel = SRC_ADD;
    if (a_full && m_full) sel = src_e'(prio_bit);
    else if (m_full)      sel = SRC_MUL;
  end

  assign any_full = a_full | m_full;
  assign wr_fire  = any_full & ~bus.full_out;
  assign a_clear  = wr_fire & (sel == SRC_ADD);
  assign m_clear  = wr_fire & (sel == SRC_MUL);

  // Priority flips on every completed write and freezes under backpressure
  d_ff_async_en #(.WIDTH(1)) u_prio (
    .clk (clk),
    .rst (rst),
    .en  (wr_fire),
    .d   (~prio_bit),
    .q   (prio_bit)
  );

  d_ff_async_en #(.WIDTH(16)) u_count (
    .clk (clk),
    .rst (rst),
    .en  (wr_fire),
    .d   (count + 16'd1),
    .q   (count)
  );

  always_comb begin
    entry = '0;
    if (any_full) begin
      if (sel == SRC_ADD)
        entry = FIFO_OUT_WIDTH'({a_slot_result, a_slot_id, OPERATION_SIZE'(src_to_op(SRC_ADD))});
      else
        entry = FIFO_OUT_WIDTH'({m_slot_result, m_slot_id, OPERATION_SIZE'(src_to_op(SRC_MUL))});
    end
  end

  assign bus.a_res_ready   = ~a_full;
  assign bus.m_res_ready   = ~m_full;
  assign bus.w_en_out      = wr_fire;
  assign bus.fifo_out_data = entry;
  assign bus.wr_count      = count;

endmodule

// File: tb/tb_out_alu_control_unit.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_out_alu_control_unit;

  import out_alu_control_unit_pkg::*;

  localparam int DW = DATA_SIZE;
  localparam int IW = ID_SIZE;
  localparam int OW = OPERATION_SIZE;
  localparam int FW = FIFO_OUT_WIDTH;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  out_alu_control_unit_if #(.DATA_SIZE(DW), .ID_SIZE(IW), .OPERATION_SIZE(OW), .FIFO_OUT_WIDTH(FW)) bus ();

  out_alu_control_unit #(.DATA_SIZE(DW), .ID_SIZE(IW), .OPERATION_SIZE(OW), .FIFO_OUT_WIDTH(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending result per source (0 = ADD, 1 = MUL), whose turn it is, writes done
  bit              ref_full [2];
  logic [DW-1:0]   ref_res  [2];
  logic [IW-1:0]   ref_id   [2];
  int              ref_turn;
  int              ref_count;
  int              ref_accepts;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_pick();
    if (ref_full[0] && ref_full[1]) return ref_turn;
    if (ref_full[0]) return 0;
    if (ref_full[1]) return 1;
    return -1;
  endfunction

  function automatic logic [FW-1:0] ref_entry();
    int s;
    logic [OW-1:0] op;
    s = ref_pick();
    if (s < 0) return '0;
    op = (s == 0) ? 2'b01 : 2'b10;
    return {ref_res[s], ref_id[s], op};
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 2; i++) begin
      ref_full[i] = 1'b0;
      ref_res[i]  = '0;
      ref_id[i]   = '0;
    end
    ref_turn    = 0;
    ref_count   = 0;
    ref_accepts = 0;
  endtask

  task automatic check_model();
    int s;
    s = ref_pick();
    check_eq("a_res_ready", 64'(bus.a_res_ready), 64'(!ref_full[0]));
    check_eq("m_res_ready", 64'(bus.m_res_ready), 64'(!ref_full[1]));
    check_eq("w_en_out", 64'(bus.w_en_out), 64'((s >= 0) && !bus.full_out));
    check_eq("fifo_out_data", 64'(bus.fifo_out_data), 64'(ref_entry()));
    check_eq("wr_count", 64'(bus.wr_count), 64'(ref_count));
  endtask

  task automatic model_edge(input bit av, input bit mv, input bit fo,
                            input logic [DW-1:0] ar, input logic [DW-1:0] mr,
                            input logic [IW-1:0] ai, input logic [IW-1:0] mi);
    int s;
    bit acc_a, acc_m;
    s     = ref_pick();
    acc_a = av && !ref_full[0];
    acc_m = mv && !ref_full[1];
    if (s >= 0 && !fo) begin
      ref_full[s] = 1'b0;
      ref_count   = (ref_count + 1) % 65536;
      ref_turn    = 1 - ref_turn;
    end
    if (acc_a) begin ref_full[0] = 1'b1; ref_res[0] = ar; ref_id[0] = ai; ref_accepts++; end
    if (acc_m) begin ref_full[1] = 1'b1; ref_res[1] = mr; ref_id[1] = mi; ref_accepts++; end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge, return 1 time unit later
  task automatic step();
    bit av, mv, fo;
    logic [DW-1:0] ar, mr;
    logic [IW-1:0] ai, mi;
    @(negedge clk);
    check_model();
    av = bus.a_valid_res; mv = bus.m_valid_res; fo = bus.full_out;
    ar = bus.a_result;    mr = bus.m_result;
    ai = bus.a_id;        mi = bus.m_id;
    @(posedge clk);
    model_edge(av, mv, fo, ar, mr, ai, mi);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid_res = 1'b0; bus.a_result = '0; bus.a_id = '0;
    bus.m_valid_res = 1'b0; bus.m_result = '0; bus.m_id = '0;
    bus.full_out    = 1'b0;
  endtask

  task automatic drive_add(input logic [DW-1:0] r, input logic [IW-1:0] i);
    bus.a_valid_res = 1'b1; bus.a_result = r; bus.a_id = i;
  endtask

  task automatic drive_mul(input logic [DW-1:0] r, input logic [IW-1:0] i);
    bus.m_valid_res = 1'b1; bus.m_result = r; bus.m_id = i;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check_eq("rst_a_ready", 64'(bus.a_res_ready), 64'd1);
    check_eq("rst_m_ready", 64'(bus.m_res_ready), 64'd1);
    check_eq("rst_w_en", 64'(bus.w_en_out), 64'd0);
    check_eq("rst_data", 64'(bus.fifo_out_data), 64'd0);
    check_eq("rst_count", 64'(bus.wr_count), 64'd0);
    ref_clear();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    ref_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Single add
    drive_add(16'h1234, 8'h05);
    step();
    idle_inputs();
    check_eq("single_w_en", 64'(bus.w_en_out), 64'd1);
    check_eq("single_data", 64'(bus.fifo_out_data), 64'({16'h1234, 8'h05, 2'b01}));
    step();
    check_eq("single_w_en_done", 64'(bus.w_en_out), 64'd0);
    check_eq("single_count", 64'(bus.wr_count), 64'd1);

    // Simultaneous add and mul: ADD first, MUL on the next cycle
    do_reset();
    drive_add(16'h0011, 8'h01);
    drive_mul(16'h00C8, 8'h02);
    step();
    idle_inputs();
    check_eq("simul_w_en_1", 64'(bus.w_en_out), 64'd1);
    check_eq("simul_data_1", 64'(bus.fifo_out_data), 64'({16'h0011, 8'h01, 2'b01}));
    step();
    check_eq("simul_w_en_2", 64'(bus.w_en_out), 64'd1);
    check_eq("simul_data_2", 64'(bus.fifo_out_data), 64'({16'h00C8, 8'h02, 2'b10}));
    step();
    check_eq("simul_w_en_3", 64'(bus.w_en_out), 64'd0);
    check_eq("simul_count", 64'(bus.wr_count), 64'd2);

    // Backpressure for 5 cycles with both slots full
    do_reset();
    drive_add(16'hA5A5, 8'h10);
    drive_mul(16'h5A5A, 8'h20);
    bus.full_out = 1'b1;
    step();
    bus.a_valid_res = 1'b0;
    bus.m_valid_res = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_w_en", 64'(bus.w_en_out), 64'd0);
      check_eq("bp_a_ready", 64'(bus.a_res_ready), 64'd0);
      check_eq("bp_m_ready", 64'(bus.m_res_ready), 64'd0);
      check_eq("bp_data", 64'(bus.fifo_out_data), 64'({16'hA5A5, 8'h10, 2'b01}));
      step();
    end
    bus.full_out = 1'b0;
    #1;
    check_eq("bp_rel_data_1", 64'(bus.fifo_out_data), 64'({16'hA5A5, 8'h10, 2'b01}));
    step();
    check_eq("bp_rel_data_2", 64'(bus.fifo_out_data), 64'({16'h5A5A, 8'h20, 2'b10}));
    step();
    check_eq("bp_count", 64'(bus.wr_count), 64'd2);

    // Both sources continuously valid for 10 cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_add(DW'(16'h1000 + i), IW'(2 * i));
      drive_mul(DW'(16'h2000 + i), IW'(2 * i + 1));
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();
    check_eq("rr_all_written", 64'(bus.wr_count), 64'(ref_accepts));
    check_eq("rr_drained", 64'(bus.w_en_out), 64'd0);

    // Reset while both slots are held under backpressure
    do_reset();
    drive_add(16'h0F0F, 8'h44);
    drive_mul(16'hF0F0, 8'h55);
    bus.full_out = 1'b1;
    step();
    idle_inputs();
    bus.full_out = 1'b1;
    step();
    check_eq("mid_a_ready_busy", 64'(bus.a_res_ready), 64'd0);
    do_reset();
    bus.full_out = 1'b0;
    drive_mul(16'h0BEE, 8'h33);
    step();
    idle_inputs();
    check_eq("mid_first_w_en", 64'(bus.w_en_out), 64'd1);
    check_eq("mid_first_data", 64'(bus.fifo_out_data), 64'({16'h0BEE, 8'h33, 2'b10}));
    step();
    check_eq("mid_count", 64'(bus.wr_count), 64'd1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.a_valid_res = 1'($urandom_range(0, 1));
      bus.m_valid_res = 1'($urandom_range(0, 1));
      bus.a_result    = DW'($urandom);
      bus.m_result    = DW'($urandom);
      bus.a_id        = IW'($urandom);
      bus.m_id        = IW'($urandom);
      bus.full_out    = ($urandom_range(0, 3) == 0);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // Counter wrap: saturate writes at one per cycle until 0xFFFF, then one more
    do_reset();
    drive_add(16'h7777, 8'h01);
    drive_mul(16'h8888, 8'h02);
    for (int i = 0; i < 70000 && ref_count != 65535; i++) step();
    check_eq("wrap_pre_count", 64'(bus.wr_count), 64'h0000_FFFF);
    check_eq("wrap_pre_w_en", 64'(bus.w_en_out), 64'd1);
    step();
    check_eq("wrap_count", 64'(bus.wr_count), 64'd0);

    idle_inputs();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/out_alu_control_unit.md
OUT_ALU_CONTROL_UNIT -- requirements
Module: out_alu_control_unit

Interface
REQ-001 Parameter DATA_SIZE, default 16, result width of both adder and multiplier.
REQ-002 Parameter ID_SIZE, default 8, transaction ID width.
REQ-003 Parameter OPERATION_SIZE, default 2, operation tag width.
REQ-004 Parameter FIFO_OUT_WIDTH, default DATA_SIZE+ID_SIZE+OPERATION_SIZE, FIFO_OUT entry width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 a_valid_res  input  1  adder result valid.
REQ-008 a_result  input  DATA_SIZE  adder result.
REQ-009 a_id  input  ID_SIZE  ID of the adder result.
REQ-010 a_res_ready  output  1  block can accept an adder result.
REQ-011 m_valid_res  input  1  multiplier result valid.
REQ-012 m_result  input  DATA_SIZE  multiplier result (8x8 product).
REQ-013 m_id  input  ID_SIZE  ID of the multiplier result.
REQ-014 m_res_ready  output  1  block can accept a multiplier result.
REQ-015 full_out  input  1  FIFO_OUT full.
REQ-016 w_en_out  output  1  FIFO_OUT write strobe.
REQ-017 fifo_out_data  output  FIFO_OUT_WIDTH  entry {result, id, op}, op in bits [OPERATION_SIZE-1:0], id next, result in MSBs.
REQ-018 wr_count  output  16  count of entries written to FIFO_OUT.

Function
REQ-019 The block SHALL hold one result slot per source (ADD slot, MUL slot); each slot stores result, ID and a full flag.
REQ-020 x_res_ready SHALL equal NOT(slot full), driven from the registered flag with no combinational path from full_out.
REQ-021 A slot SHALL capture {x_result, x_id} and set full on a rising edge where x_valid_res=1 and x_res_ready=1; x_valid_res while not ready SHALL be ignored and not queued.
REQ-022 A slot is a grant candidate while full; if exactly one slot is full, that slot SHALL be selected.
REQ-023 If both slots are full, selection SHALL be round-robin: priority bit resets to ADD and flips to the other source after every completed write.
REQ-024 w_en_out SHALL be combinational: 1 when any slot is full and full_out=0, else 0.
REQ-025 fifo_out_data SHALL be the selected slot's {result, id, op}, op = 2'b01 for ADD, 2'b10 for MUL; it SHALL be 0 when no slot is full.
REQ-026 On an edge with w_en_out=1, the selected slot SHALL clear and wr_count SHALL increment by 1, wrapping 0xFFFF->0x0000.
REQ-027 Latency: a result accepted at edge k with full_out=0 and no contention SHALL have w_en_out=1 in the cycle after edge k and be written at edge k+1.
REQ-028 Per-source throughput SHALL be one result per 2 cycles; both sources together SHALL sustain one write per cycle.
REQ-029 While full_out=1, no write SHALL occur, slots SHALL hold, and the priority bit SHALL not change.
REQ-030 Capture and drain SHALL never target the same slot on the same edge, because ready is low while the slot is full.

Reset
REQ-031 On rst=1, asynchronously: both slots SHALL become empty with zeroed data, the priority bit SHALL become ADD, and wr_count SHALL become 0.
REQ-032 During reset, outputs SHALL be a_res_ready=1, m_res_ready=1, w_en_out=0, fifo_out_data=0 and wr_count=0; slot contents held at reset assertion SHALL be discarded.

Structure
REQ-033 DATA_SIZE, ID_SIZE, OPERATION_SIZE, FIFO_OUT_WIDTH and the op codes OP_ADD=2'b01 and OP_MUL=2'b10 SHALL live in the shared ALU definitions package/header.
REQ-034 The one-entry holding register SHALL be a sub-module result_slot, instantiated twice, built from the existing d_ff_async_en flop.

Verification
REQ-035 Single add: a_result=0x1234, a_id=0x05, full_out=0 -> one w_en_out pulse, fifo_out_data={0x1234,0x05,01}, wr_count=1.
REQ-036 Simultaneous: add (0x0011, id 1) and mul (0x00C8, id 2) on the same edge -> ADD written first, MUL next cycle, w_en_out high 2 consecutive cycles.
REQ-037 Backpressure: full_out=1 for 5 cycles with both slots full -> w_en_out=0, both ready=0, no data change; after release, 2 writes in order ADD then MUL.
REQ-038 Round-robin: both sources continuously valid for 10 cycles -> writes alternate ADD/MUL, IDs intact, none lost or duplicated.
REQ-039 Reset mid-operation: rst pulsed with both slots full -> both ready=1, w_en_out=0, wr_count=0; the next single mul is written as the first entry.
REQ-040 Wrap: preload 65535 writes, then 1 more -> wr_count=0x0000.
